// File: rtl/uart_inst_rx_if.sv
// rtl/uart_inst_rx_if.sv - instruction valid/ready handshake between the UART receiver and the decoder
// Signals:
//   inst_wd   instruction byte at FIFO head
//   inst_vld  head entry present
//   inst_rdy  consumer accepts inst_wd when inst_vld & inst_rdy
// master = receiver side, slave = decoder side.
interface uart_inst_rx_if;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       inst_rdy;

  modport master (output inst_wd, output inst_vld, input inst_rdy);
  modport slave  (input inst_wd, input inst_vld, output inst_rdy);
endinterface

// File: rtl/uart_inst_rx.sv
// rtl/uart_inst_rx.sv - oversampling 8N1 UART receiver feeding a small instruction FIFO
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   rx       asynchronous serial input, idle high, LSB first
//   inst_if  master side of the instruction handshake (inst_wd/inst_vld/inst_rdy)
//   frm_err  one-cycle pulse when a stop bit is sampled low
//   ovf      one-cycle pulse when a byte is dropped because the FIFO is full
//   busy     receiver is inside a frame
module uart_inst_rx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  uart_inst_rx_if.master  inst_if,
  output logic            frm_err,
  output logic            ovf,
  output logic            busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t        state_q, state_d;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          cnt_clr, shift_en, push, frm_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count;
  logic [7:0]    wd_q;
  logic          pop, full, wr_en;

  // Two-flop synchronizer; resets to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    frm_set  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Half-bit wait centres all later samples in their bit cells.
        if (cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frm_set = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_clr = 1'b1;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state_q == IDLE) bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end
  end

  assign busy = (state_q != IDLE);

  // FIFO: a pop frees a slot in the same cycle, so a push into a full FIFO with a pop is kept.
  assign pop    = inst_if.inst_vld & inst_if.inst_rdy;
  assign full   = (count == CNT_FULL);
  assign wr_en  = push & (~full | pop);
  assign rd_nxt = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wd_q    <= 8'h00;
      frm_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_nxt;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head register: the incoming byte becomes head when nothing older will remain.
      if (wr_en && (count == '0 || (pop && count == CNT_ONE))) wd_q <= shreg;
      else if (pop)                                          wd_q <= mem[rd_nxt];
      frm_err <= frm_set;
      ovf     <= push & full & ~pop;
    end
  end

  assign inst_if.inst_wd  = wd_q;
  assign inst_if.inst_vld = (count != '0);

endmodule

// File: tb/tb_uart_inst_rx.sv
// tb/tb_uart_inst_rx.sv - self-checking bench for uart_inst_rx
module tb_uart_inst_rx;
  localparam int N = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frm_err, ovf, busy;

  uart_inst_rx_if u_if ();

  uart_inst_rx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .inst_if (u_if),
    .frm_err (frm_err),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int frm_cnt = 0;
  int ovf_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (frm_err) frm_cnt++;
    if (ovf)     ovf_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_vld;
    logic [7:0] exp_wd;
    int         exp_frm;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Called at a negedge; leaves rx at the stop-bit level and returns at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = stop_bit;
    repeat (N) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    u_if.inst_rdy = 1'b1;
    @(negedge clk);
    u_if.inst_rdy = 1'b0;
  endtask

  int f0, o0, c0, lat;
  logic [7:0] exp_seq [4];

  initial begin
    u_if.inst_rdy = 1'b0;
    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};

    repeat (3) @(negedge clk);
    check("rst_vld", u_if.inst_vld, 0);
    check("rst_wd", u_if.inst_wd, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_frm", frm_err, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame latency
    c0 = cyc;
    fork
      send_frame(8'h34, 1'b1);
      begin
        for (int k = 0; k < 1100 && !u_if.inst_vld; k++) @(negedge clk);
        lat = cyc - c0;
        check("lat_range", (lat >= 952 && lat <= 956), 1);
        check("lat_wd", u_if.inst_wd, 8'h34);
      end
    join
    repeat (20) @(negedge clk);
    check("hold_vld", u_if.inst_vld, 1);
    pop_one();
    check("pop_empty", u_if.inst_vld, 0);
    repeat (20) @(negedge clk);

    // Table of single frames
    foreach (vecs[i]) begin
      f0 = frm_cnt;
      send_frame(vecs[i].data, vecs[i].stop_bit);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_vld", i), u_if.inst_vld, vecs[i].exp_vld);
      if (vecs[i].exp_vld) check($sformatf("vec%0d_wd", i), u_if.inst_wd, vecs[i].exp_wd);
      check($sformatf("vec%0d_frm", i), frm_cnt - f0, vecs[i].exp_frm);
      if (u_if.inst_vld) pop_one();
      repeat (20) @(negedge clk);
    end

    // Five back-to-back frames into a 4-deep FIFO
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_ovf", ovf_cnt - o0, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("b2b_wd%0d", i), u_if.inst_wd, i);
      check($sformatf("b2b_vld%0d", i), u_if.inst_vld, 1);
      pop_one();
    end
    check("b2b_empty", u_if.inst_vld, 0);
    repeat (20) @(negedge clk);

    // Short low glitch
    f0 = frm_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_hi", busy, 1);
    repeat (25) @(negedge clk);
    rx = 1'b1;
    repeat (55) @(negedge clk);
    check("glitch_busy_lo", busy, 0);
    check("glitch_vld", u_if.inst_vld, 0);
    check("glitch_frm", frm_cnt - f0, 0);
    repeat (20) @(negedge clk);

    // Framing error then a clean frame
    f0 = frm_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (N) @(negedge clk);
    check("ferr_busy", busy, 1);
    rx = 1'b1;
    repeat (N) @(negedge clk);
    check("ferr_cnt", frm_cnt - f0, 1);
    check("ferr_nopush", u_if.inst_vld, 0);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("ferr_next_vld", u_if.inst_vld, 1);
    check("ferr_next_wd", u_if.inst_wd, 8'h5A);
    pop_one();
    repeat (20) @(negedge clk);

    // Full FIFO with a pop coinciding with the push
    o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check("full_noovf", ovf_cnt - o0, 0);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (952) @(negedge clk);
        u_if.inst_rdy = 1'b1;
        @(negedge clk);
        u_if.inst_rdy = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("pp_noovf", ovf_cnt - o0, 0);
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h12; exp_seq[2] = 8'h13; exp_seq[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_wd%0d", i), u_if.inst_wd, exp_seq[i]);
      check($sformatf("pp_vld%0d", i), u_if.inst_vld, 1);
      pop_one();
    end
    check("pp_empty", u_if.inst_vld, 0);
    repeat (20) @(negedge clk);

    // Reset in the middle of a frame
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("pre_rst_wd", u_if.inst_wd, 8'h3C);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_vld", u_if.inst_vld, 0);
        check("mid_rst_wd", u_if.inst_wd, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frm", frm_err, 0);
        check("mid_rst_ovf", ovf, 0);
      end
    join
    repeat (200) @(negedge clk);
    check("post_rst_nopush", u_if.inst_vld, 0);
    send_frame(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_vld", u_if.inst_vld, 1);
    check("post_rst_wd", u_if.inst_wd, 8'h12);
    pop_one();
    check("post_rst_empty", u_if.inst_vld, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
